fsk_symstreamer: RTL and testbench
==================================

# fsk_symstreamer

Parametrised M-ary FSK symbol streamer. It drives a differential pulse pair (outp/outn) for an antenna-modulation transmit path, with one full square-wave period per symbol. Each symbol value has its own runtime-programmable half-period, and a common fractional phase offset is scaled per symbol. Consecutive symbols are emitted back-to-back with no idle gap. The block supports multi-bit symbols, a programmable symbol count, continuous repeat, and abort.

## Interface
Parameters:
- DATALEN, 64: width of the payload word.
- BPS, 1: bits per symbol (1..3); NSYM = 2**BPS symbol values.
- CNTLEN, 16: width of the period counters and the half-period entries.
- PH_W, 8: width of the phase fraction.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- datain  in  DATALEN  payload, sent LSB-first, BPS bits per symbol.
- half_period  in  NSYM*CNTLEN  flat table; entry s is half-period H[s] in clk cycles.
- phase_frac  in  PH_W  phase offset as a fraction of H, in units of 2**-PH_W.
- nsym  in  CNTLEN  number of symbols per pass; 0 means DATALEN/BPS.
- repeat  in  1  restart from the latched word after the last symbol.
- start  in  1  begin a transmission when idle.
- abort  in  1  synchronous stop.
- sysrun  out  1  high while a transmission is active.
- outp, outn  out  1  differential drive.
- symout  out  BPS  value of the symbol currently being emitted.
- sym_strobe  out  1  one-cycle pulse on the first cycle of each symbol.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- Per-symbol parameters, for symbol value s:
  - H = max(H[s], 1).
  - P = (phase_frac * H) >> PH_W, so 0 <= P < H when H > 1.
- Waveform for one symbol, 2H cycles long:
  - HEAD: P cycles with outp=1, outn=0.
  - LOW: H cycles with outp=0, outn=1.
  - TAIL: H-P cycles with outp=1, outn=0.
  - A zero-length HEAD or TAIL is skipped with no cycle lost.
- States: IDLE, ARM, HEAD, LOW, TAIL.
- IDLE:
  - Outputs 0.
  - On start, latch datain, phase_frac, nsym and repeat; go to ARM.
  - The half_period table is not latched; it is sampled per symbol.
- ARM, 1 cycle: compute H and P for symbol 0; go to HEAD, or to LOW if P=0.
- Prefetch: during the last cycle of each TAIL (or LOW when the tail is 0), compute H and P for the next symbol, so the next HEAD starts on the following cycle.
- Symbol sequencing:
  - The shift register shifts right by BPS per symbol.
  - A symbol counter compares against the effective nsym.
- After the last symbol:
  - If repeat is high (latched value), reload the latched word and continue with no gap.
  - Otherwise go to IDLE and pulse done.
- Boundary conditions:
  - nsym greater than DATALEN/BPS is clamped to DATALEN/BPS.
  - start while sysrun=1 is ignored.
  - abort takes priority over all other conditions: next edge goes to IDLE, outputs 0, no done pulse.
  - abort together with start in IDLE: stay in IDLE.
  - outp and outn are never both 1.
  - Reset mid-symbol: outputs drop to 0 immediately (asynchronous).

## Timing
- Reset values: sysrun, outp, outn, sym_strobe and done are 0; symout is 0; state is IDLE.
- All outputs are registered.
- start sampled high at edge n:
  - sysrun=1 after edge n+1.
  - First waveform cycle and first sym_strobe after edge n+2.
- Each symbol lasts exactly 2H cycles.
- symout and sym_strobe update on the first cycle of each symbol.
- done pulses on the first cycle after the final TAIL, in the same cycle that sysrun falls.
- A new start is accepted on the cycle after done.
- Counters are CNTLEN wide.
- The multiply is PH_W x CNTLEN; only the low CNTLEN bits of the shifted result are kept.

## Structure
- Shared package fsk_pkg holds:
  - the state encoding (one-hot, 5 states);
  - the NSYM and effective-nsym helper functions;
  - the phase-scaling function.
- Sub-module fsk_phase_calc: given symbol value and table, registers H, P and H-P in one cycle. It is used by ARM and by the prefetch.
- The top level holds the FSM, shift register, symbol counter and cycle counter.

## Test plan
- BPS=1, H[0]=8, H[1]=16, phase_frac=64 (PH_W=8), datain=...0b10, nsym=2:
  - Symbol 0: 2 high, 8 low, 6 high.
  - Symbol 1: 4 high, 16 low, 12 high.
  - done at cycle start+2+48.
- phase_frac=0 and phase_frac=255 with H=4:
  - HEAD is skipped in the first case, TAIL length 4.
  - P=3, TAIL=1 in the second case.
  - Period is 8 in both.
- BPS=2, H table = {4,6,8,10}, datain=0xE4, nsym=4: symout sequence 0,1,2,3; periods 8,12,16,20; no gap cycles.
- repeat=1, nsym=3: the waveform repeats seamlessly. Assert abort mid-LOW: outputs 0 and sysrun=0 next cycle, no done.
- start pulsed during a run is ignored.
- rst_n low mid-HEAD: outputs 0 asynchronously.
- nsym=0 with DATALEN=8, BPS=1: exactly 8 symbols are sent.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared types and helpers for the M-ary FSK symbol streamer.
package fsk_pkg;

   typedef enum logic [4:0] {
      ST_IDLE = 5'b00001,
      ST_ARM  = 5'b00010,
      ST_HEAD = 5'b00100,
      ST_LOW  = 5'b01000,
      ST_TAIL = 5'b10000
   } state_e;

   localparam int B_IDLE = 0;
   localparam int B_ARM  = 1;
   localparam int B_HEAD = 2;
   localparam int B_LOW  = 3;
   localparam int B_TAIL = 4;

   function automatic int unsigned nsym_of(input int unsigned bps);
      return 32'd1 << bps;
   endfunction

   // 0 or an over-long count both mean "the whole word"
   function automatic int unsigned eff_nsym(
      input int unsigned n,
      input int unsigned maxs
   );
      if (n == 0 || n > maxs) return maxs;
      return n;
   endfunction

   function automatic logic [63:0] phase_scale(
      input logic [31:0] pf,
      input logic [31:0] h,
      input int unsigned ph_w
   );
      logic [63:0] prod;
      prod = {32'd0, pf} * {32'd0, h};
      return prod >> ph_w;
   endfunction

endpackage

// File: rtl/fsk_phase_calc.sv
// Per-symbol timing: looks up H for a symbol value and registers H, P, H-P.
module fsk_phase_calc
   import fsk_pkg::*;
#(
   parameter int BPS    = 1,
   parameter int CNTLEN = 16,
   parameter int PH_W   = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_en,
   input  logic [BPS-1:0]                 i_sym,
   input  logic [nsym_of(BPS)*CNTLEN-1:0] i_table,
   input  logic [PH_W-1:0]                i_pf,
   output logic [CNTLEN-1:0]              o_h,
   output logic [CNTLEN-1:0]              o_p,
   output logic [CNTLEN-1:0]              o_hp,
   output logic                           o_pz
);

   localparam int NSYM = int'(nsym_of(BPS));

   logic [CNTLEN-1:0] w_tab [NSYM];
   logic [CNTLEN-1:0] w_raw;
   logic [CNTLEN-1:0] w_h;
   logic [CNTLEN-1:0] w_p;
   logic [CNTLEN-1:0] r_h;
   logic [CNTLEN-1:0] r_p;
   logic [CNTLEN-1:0] r_hp;

   genvar g;
   for (g = 0; g < NSYM; g++) begin : g_tab
      assign w_tab[g] = i_table[g*CNTLEN +: CNTLEN];
   end

   assign w_raw = w_tab[i_sym];
   assign w_h   = (w_raw == '0) ? CNTLEN'(1) : w_raw;
   assign w_p   = CNTLEN'(phase_scale(32'(i_pf), 32'(w_h), PH_W));

   // the FSM needs to know about an empty HEAD before the values land
   assign o_pz  = (w_p == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h  <= '0;
         r_p  <= '0;
         r_hp <= '0;
      end else if (i_en) begin
         r_h  <= w_h;
         r_p  <= w_p;
         r_hp <= w_h - w_p;
      end
   end

   assign o_h  = r_h;
   assign o_p  = r_p;
   assign o_hp = r_hp;

endmodule

// File: rtl/fsk_symstreamer.sv
// M-ary FSK symbol streamer: one square-wave period per symbol on outp/outn.
module fsk_symstreamer
   import fsk_pkg::*;
#(
   parameter int DATALEN = 64,
   parameter int BPS     = 1,
   parameter int CNTLEN  = 16,
   parameter int PH_W    = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [DATALEN-1:0]             datain,
   input  logic [nsym_of(BPS)*CNTLEN-1:0] half_period,
   input  logic [PH_W-1:0]                phase_frac,
   input  logic [CNTLEN-1:0]              nsym,
   input  logic                           repeat_en,
   input  logic                           start,
   input  logic                           abort,
   output logic                           sysrun,
   output logic                           outp,
   output logic                           outn,
   output logic [BPS-1:0]                 symout,
   output logic                           sym_strobe,
   output logic                           done
);

   localparam int MAXSYM = DATALEN / BPS;

   state_e r_state;
   state_e w_state_nxt;

   logic [DATALEN-1:0] r_word;
   logic [DATALEN-1:0] r_shift;
   logic [DATALEN-1:0] w_next_word;
   logic [PH_W-1:0]    r_pf;
   logic [CNTLEN-1:0]  r_neff;
   logic [CNTLEN-1:0]  r_symcnt;
   logic [CNTLEN-1:0]  r_cnt;
   logic               r_rep;
   logic               r_first;
   logic               r_fin;

   logic               r_sysrun;
   logic               r_outp;
   logic               r_outn;
   logic [BPS-1:0]     r_symout;
   logic               r_strobe;
   logic               r_done;

   logic [CNTLEN-1:0]  w_h;
   logic [CNTLEN-1:0]  w_p;
   logic [CNTLEN-1:0]  w_hp;
   logic               w_pz;
   logic               w_pc_en;
   logic [BPS-1:0]     w_pc_sym;

   logic w_last;
   logic w_start;
   logic w_sym_end;
   logic w_new_sym;
   logic w_finish;
   logic w_head_end;
   logic w_low_end;
   logic w_tail_end;

   fsk_phase_calc #(
      .BPS    (BPS),
      .CNTLEN (CNTLEN),
      .PH_W   (PH_W)
   ) u_calc (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_pc_en),
      .i_sym   (w_pc_sym),
      .i_table (half_period),
      .i_pf    (r_pf),
      .o_h     (w_h),
      .o_p     (w_p),
      .o_hp    (w_hp),
      .o_pz    (w_pz)
   );

   assign w_last      = (r_symcnt == r_neff - 1'b1);
   assign w_next_word = w_last ? r_word : (r_shift >> BPS);
   assign w_pc_sym    = r_state[B_ARM] ? r_shift[BPS-1:0]
                                       : w_next_word[BPS-1:0];

   assign w_head_end  = (r_cnt == w_p - 1'b1);
   assign w_low_end   = (r_cnt == w_h - 1'b1);
   assign w_tail_end  = (r_cnt == w_hp - 1'b1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_sym_end   = 1'b0;
      w_new_sym   = 1'b0;
      w_finish    = 1'b0;
      w_pc_en     = 1'b0;
      unique case (1'b1)
         r_state[B_IDLE]: begin
            if (start && !r_sysrun) begin
               w_start     = 1'b1;
               w_state_nxt = ST_ARM;
            end
         end
         r_state[B_ARM]: begin
            w_pc_en     = 1'b1;
            w_new_sym   = 1'b1;
            w_state_nxt = w_pz ? ST_LOW : ST_HEAD;
         end
         r_state[B_HEAD]: begin
            if (w_head_end) w_state_nxt = ST_LOW;
         end
         r_state[B_LOW]: begin
            if (w_low_end) begin
               if (w_hp != '0) w_state_nxt = ST_TAIL;
               else            w_sym_end   = 1'b1;
            end
         end
         r_state[B_TAIL]: begin
            if (w_tail_end) w_sym_end = 1'b1;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      // last cycle of a symbol doubles as the prefetch slot for the next
      if (w_sym_end) begin
         if (w_last && !r_rep) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
         end else begin
            w_pc_en     = 1'b1;
            w_new_sym   = 1'b1;
            w_state_nxt = w_pz ? ST_LOW : ST_HEAD;
         end
      end
      if (abort) begin
         w_state_nxt = ST_IDLE;
         w_start     = 1'b0;
         w_sym_end   = 1'b0;
         w_new_sym   = 1'b0;
         w_finish    = 1'b0;
         w_pc_en     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word   <= '0;
         r_shift  <= '0;
         r_pf     <= '0;
         r_neff   <= '0;
         r_rep    <= 1'b0;
         r_symcnt <= '0;
      end else if (w_start) begin
         r_word   <= datain;
         r_shift  <= datain;
         r_pf     <= phase_frac;
         r_neff   <= CNTLEN'(eff_nsym(32'(nsym), MAXSYM));
         r_rep    <= repeat_en;
         r_symcnt <= '0;
      end else if (w_sym_end && w_new_sym) begin
         r_shift  <= w_next_word;
         r_symcnt <= w_last ? '0 : r_symcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_first <= 1'b0;
         r_fin   <= 1'b0;
      end else begin
         if (w_new_sym || w_state_nxt != r_state || r_state[B_IDLE])
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
         r_first <= w_new_sym;
         r_fin   <= w_finish;
      end
   end

   // outputs trail the state by one cycle; abort clears them at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sysrun <= 1'b0;
         r_outp   <= 1'b0;
         r_outn   <= 1'b0;
         r_symout <= '0;
         r_strobe <= 1'b0;
         r_done   <= 1'b0;
      end else if (abort) begin
         r_sysrun <= 1'b0;
         r_outp   <= 1'b0;
         r_outn   <= 1'b0;
         r_symout <= '0;
         r_strobe <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_sysrun <= !r_state[B_IDLE];
         r_outp   <= r_state[B_HEAD] | r_state[B_TAIL];
         r_outn   <= r_state[B_LOW];
         r_symout <= (r_state[B_HEAD] | r_state[B_LOW] | r_state[B_TAIL])
                     ? r_shift[BPS-1:0] : '0;
         r_strobe <= r_first;
         r_done   <= r_fin;
      end
   end

   assign sysrun     = r_sysrun;
   assign outp       = r_outp;
   assign outn       = r_outn;
   assign symout     = r_symout;
   assign sym_strobe = r_strobe;
   assign done       = r_done;

endmodule

// File: tb/tb_fsk_symstreamer.sv
// Directed bench for fsk_symstreamer: vector table plus corner sequences.
module tb_fsk_symstreamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  din;
   logic [63:0] hp;
   logic [7:0]  pf;
   logic [15:0] ns;
   logic        rep;
   logic        abort;
   logic        start1;
   logic        start2;

   logic       sr1, op1, on1, st1, dn1;
   logic [0:0] sym1;
   logic       sr2, op2, on2, st2, dn2;
   logic [1:0] sym2;

   int   cur;
   logic m_sr, m_op, m_on, m_st, m_dn;
   int   m_sym;

   int nchk  = 0;
   int nfail = 0;

   typedef struct {
      int          sel;
      logic [7:0]  din;
      int          h[4];
      int          pf;
      int          ns;
      int          nexp;
      logic [15:0] eseq;
      int          eh[4];
      int          el[4];
      int          et[4];
      int          edone;
      int          restart_at;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   fsk_symstreamer #(
      .DATALEN (8), .BPS (1), .CNTLEN (16), .PH_W (8)
   ) u1 (
      .clk (clk), .rst_n (rst_n), .datain (din),
      .half_period (hp[31:0]), .phase_frac (pf), .nsym (ns),
      .repeat_en (rep), .start (start1), .abort (abort),
      .sysrun (sr1), .outp (op1), .outn (on1), .symout (sym1),
      .sym_strobe (st1), .done (dn1)
   );

   fsk_symstreamer #(
      .DATALEN (8), .BPS (2), .CNTLEN (16), .PH_W (8)
   ) u2 (
      .clk (clk), .rst_n (rst_n), .datain (din),
      .half_period (hp), .phase_frac (pf), .nsym (ns),
      .repeat_en (rep), .start (start2), .abort (abort),
      .sysrun (sr2), .outp (op2), .outn (on2), .symout (sym2),
      .sym_strobe (st2), .done (dn2)
   );

   always_comb begin
      if (cur == 2) begin
         m_sr = sr2; m_op = op2; m_on = on2;
         m_st = st2; m_dn = dn2; m_sym = int'(sym2);
      end else begin
         m_sr = sr1; m_op = op1; m_on = on1;
         m_st = st1; m_dn = dn1; m_sym = int'(sym1);
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      nchk++;
      if (got != exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      int k, nsy, done_k, gaps, both, extra, es;
      int gs[8], gh[8], gl[8], gt[8];
      cur = v.sel;
      din = v.din;
      hp  = {16'(v.h[3]), 16'(v.h[2]), 16'(v.h[1]), 16'(v.h[0])};
      pf  = 8'(v.pf);
      ns  = 16'(v.ns);
      rep = 1'b0;
      for (int i = 0; i < 8; i++) begin
         gs[i] = -1; gh[i] = 0; gl[i] = 0; gt[i] = 0;
      end
      nsy = 0; done_k = -1; gaps = 0; both = 0; k = 0;
      @(negedge clk);
      if (v.sel == 2) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      while (k < 400 && done_k < 0) begin
         @(negedge clk);
         k++;
         start1 = 1'b0; start2 = 1'b0;
         if (k == v.restart_at) begin
            if (v.sel == 2) start2 = 1'b1; else start1 = 1'b1;
         end
         if (k == 1) begin
            chk($sformatf("v%0d_arm_sysrun", vi), int'(m_sr), 1);
         end else if (m_dn) begin
            done_k = k;
            chk($sformatf("v%0d_sysrun_at_done", vi), int'(m_sr), 0);
         end else begin
            if (m_op && m_on) both++;
            if (!m_op && !m_on) gaps++;
            if (m_st) begin
               nsy++;
               if (nsy <= 8) gs[nsy-1] = m_sym;
            end
            if (nsy >= 1 && nsy <= 8) begin
               if (m_on) gl[nsy-1]++;
               else if (m_op) begin
                  if (gl[nsy-1] == 0) gh[nsy-1]++;
                  else                gt[nsy-1]++;
               end
            end
         end
      end
      chk($sformatf("v%0d_done_cycle", vi), done_k, v.edone);
      chk($sformatf("v%0d_nsyms", vi), nsy, v.nexp);
      chk($sformatf("v%0d_gaps", vi), gaps, 0);
      chk($sformatf("v%0d_both_high", vi), both, 0);
      for (int i = 0; i < v.nexp && i < 8; i++) begin
         es = int'((v.eseq >> (2*i)) & 16'd3);
         chk($sformatf("v%0d_s%0d_sym", vi, i), gs[i], es);
         chk($sformatf("v%0d_s%0d_head", vi, i), gh[i], v.eh[es]);
         chk($sformatf("v%0d_s%0d_low", vi, i), gl[i], v.el[es]);
         chk($sformatf("v%0d_s%0d_tail", vi, i), gt[i], v.et[es]);
      end
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (m_sr || m_dn || m_op || m_on) extra++;
      end
      chk($sformatf("v%0d_idle_after", vi), extra, 0);
      if (done_k < 0) do_reset();
   endtask

   initial begin
      int found, extra, nstb, gaps, dn;
      int rs[8];
      int exp_rs[8];

      rst_n = 1'b0; din = '0; hp = '0; pf = '0; ns = '0;
      rep = 1'b0; abort = 1'b0; start1 = 1'b0; start2 = 1'b0;
      cur = 1;

      vecs.push_back('{sel:1, din:8'h02, h:'{8,16,0,0}, pf:64, ns:2,
         nexp:2, eseq:16'h0004, eh:'{2,4,0,0}, el:'{8,16,0,0},
         et:'{6,12,0,0}, edone:50, restart_at:20});
      vecs.push_back('{sel:1, din:8'h00, h:'{4,4,0,0}, pf:0, ns:1,
         nexp:1, eseq:16'h0000, eh:'{0,0,0,0}, el:'{4,4,0,0},
         et:'{4,4,0,0}, edone:10, restart_at:0});
      vecs.push_back('{sel:1, din:8'h01, h:'{4,4,0,0}, pf:255, ns:2,
         nexp:2, eseq:16'h0001, eh:'{3,3,0,0}, el:'{4,4,0,0},
         et:'{1,1,0,0}, edone:18, restart_at:0});
      vecs.push_back('{sel:2, din:8'hE4, h:'{4,6,8,10}, pf:128, ns:4,
         nexp:4, eseq:16'h00E4, eh:'{2,3,4,5}, el:'{4,6,8,10},
         et:'{2,3,4,5}, edone:58, restart_at:0});
      vecs.push_back('{sel:1, din:8'hA5, h:'{3,5,0,0}, pf:100, ns:0,
         nexp:8, eseq:16'h4411, eh:'{1,1,0,0}, el:'{3,5,0,0},
         et:'{2,4,0,0}, edone:66, restart_at:0});
      vecs.push_back('{sel:1, din:8'hFF, h:'{0,0,0,0}, pf:200, ns:20,
         nexp:8, eseq:16'h5555, eh:'{0,0,0,0}, el:'{1,1,0,0},
         et:'{1,1,0,0}, edone:18, restart_at:0});

      repeat (2) @(negedge clk);
      chk("rst_sysrun", int'(sr1), 0);
      chk("rst_outp", int'(op1), 0);
      chk("rst_outn", int'(on1), 0);
      chk("rst_strobe", int'(st1), 0);
      chk("rst_done", int'(dn1), 0);
      chk("rst_symout", int'(sym2), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_sysrun", int'(sr1), 0);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // repeat: 0,1,0 per pass, pass = 4 + 8 + 4 cycles
      cur = 1; din = 8'h02; hp = {32'd0, 16'd4, 16'd2};
      pf = 8'd0; ns = 16'd3; rep = 1'b1;
      exp_rs = '{0, 1, 0, 0, 1, 0, 0, 1};
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      @(negedge clk);
      nstb = 0; gaps = 0; dn = 0;
      for (int i = 0; i < 8; i++) rs[i] = -1;
      for (int k = 2; k <= 41; k++) begin
         @(negedge clk);
         if (m_st) begin
            if (nstb < 8) rs[nstb] = m_sym;
            nstb++;
         end
         if (!m_op && !m_on) gaps++;
         if (m_dn) dn++;
      end
      chk("rep_strobes", nstb, 8);
      chk("rep_gaps", gaps, 0);
      chk("rep_done", dn, 0);
      for (int i = 0; i < 8; i++)
         chk($sformatf("rep_sym%0d", i), rs[i], exp_rs[i]);

      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         @(negedge clk);
         if (m_on && m_sym == 1) found = 1;
      end
      chk("abort_in_low", found, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_outp", int'(m_op), 0);
      chk("abort_outn", int'(m_on), 0);
      chk("abort_sysrun", int'(m_sr), 0);
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (m_sr || m_dn || m_op || m_on) extra++;
      end
      chk("abort_quiet", extra, 0);
      rep = 1'b0;

      start1 = 1'b1; abort = 1'b1;
      @(negedge clk);
      start1 = 1'b0; abort = 1'b0;
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (m_sr || m_op || m_on) extra++;
      end
      chk("abort_start_idle", extra, 0);

      // reset while outp is high in the first HEAD
      din = 8'h02; hp = {32'd0, 16'd16, 16'd8}; pf = 8'd64; ns = 16'd2;
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      repeat (2) @(negedge clk);
      chk("head_outp", int'(m_op), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_outp", int'(m_op), 0);
      chk("async_rst_outn", int'(m_on), 0);
      chk("async_rst_sysrun", int'(m_sr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
